// File: rtl/pong_input_pkg.sv
// Shared types and defaults for the paddle input front end.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pong_input_pkg;

  // Per-player movement FSM states.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SLOW = 2'd1,
    FAST = 2'd2
  } move_state_e;

  // Resolved per-player request from the debounced up/down pair.
  typedef enum logic [1:0] {
    REQ_NONE = 2'd0,
    REQ_UP   = 2'd1,
    REQ_DOWN = 2'd2
  } move_req_e;

  localparam logic DIR_UP   = 1'b0;
  localparam logic DIR_DOWN = 1'b1;

  localparam int DEF_DEBOUNCE_CYCLES = 500000;  // 10 ms at 50 MHz
  localparam int DEF_FAST_FRAMES     = 16;
  localparam int DEF_STEP_W          = 4;
  localparam int DEF_SLOW_STEP       = 2;
  localparam int DEF_FAST_STEP       = 6;

  // Pressing both buttons cancels out, same as pressing neither.
  function automatic move_req_e resolve_req(input logic up, input logic dn);
    if (up && !dn) return REQ_UP;
    if (dn && !up) return REQ_DOWN;
    return REQ_NONE;
  endfunction

endpackage

// File: rtl/input_debounce_bit.sv
// Single-button synchroniser + debouncer with registered rising-edge pulse.
// Latency: level change reaches pressed_o 2+DEBOUNCE_CYCLES edges later; press_edge_o one edge after that.
// Backpressure: none; free-running every cycle.
// Ports: clk_i, rst_ni (async active-low), button_i (raw async), pressed_o (debounced level),
//        press_edge_o (one-cycle pulse after pressed_o rises).
module input_debounce_bit
  import pong_input_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic button_i,
  output logic pressed_o,
  output logic press_edge_o
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1_q, sync2_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             pressed_q, pressed_d;
  logic             pressed_dly_q;
  logic             edge_q;

  // Counter only runs while the synchronised level disagrees with the
  // accepted level; any agreeing cycle throws away accumulated credit.
  always_comb begin
    cnt_d     = cnt_q;
    pressed_d = pressed_q;
    if (sync2_q == pressed_q) begin
      cnt_d = '0;
    end else if (cnt_q == CNT_LAST) begin
      pressed_d = ~pressed_q;
      cnt_d     = '0;
    end else begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      sync1_q       <= 1'b0;
      sync2_q       <= 1'b0;
      cnt_q         <= '0;
      pressed_q     <= 1'b0;
      pressed_dly_q <= 1'b0;
      edge_q        <= 1'b0;
    end else begin
      sync1_q       <= button_i;
      sync2_q       <= sync1_q;
      cnt_q         <= cnt_d;
      pressed_q     <= pressed_d;
      pressed_dly_q <= pressed_q;
      edge_q        <= pressed_q & ~pressed_dly_q;
    end
  end

  assign pressed_o    = pressed_q;
  assign press_edge_o = edge_q;

endmodule

// File: rtl/paddle_input_ctrl.sv
// Multi-player paddle input: debounce all buttons, resolve up/down, one move command per frame tick.
// Latency: move outputs registered, valid the cycle after frame_tick; debounce as in input_debounce_bit.
// Backpressure: none; every frame_tick yields a command per player with a request (back-to-back allowed).
// Ports: clk, rst (async active-low), button[2*PLAYERS] (bit 2p up, 2p+1 down), frame_tick,
//        pressed, press_edge, move_valid[PLAYERS], move_dir[PLAYERS] (1=down), move_step[PLAYERS*STEP_W].
// Config: define PADDLE_ACCEL_EN to build the SLOW->FAST acceleration; otherwise every move is SLOW_STEP.
module paddle_input_ctrl
  import pong_input_pkg::*;
#(
  parameter int PLAYERS         = 2,
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
  parameter int FAST_FRAMES     = DEF_FAST_FRAMES,
  parameter int STEP_W          = DEF_STEP_W,
  parameter int SLOW_STEP       = DEF_SLOW_STEP,
  parameter int FAST_STEP       = DEF_FAST_STEP
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [2*PLAYERS-1:0]      button,
  input  logic                      frame_tick,
  output logic [2*PLAYERS-1:0]      pressed,
  output logic [2*PLAYERS-1:0]      press_edge,
  output logic [PLAYERS-1:0]        move_valid,
  output logic [PLAYERS-1:0]        move_dir,
  output logic [PLAYERS*STEP_W-1:0] move_step
);

  if (DEBOUNCE_CYCLES < 2 || FAST_FRAMES < 1 ||
      SLOW_STEP >= (1 << STEP_W) || FAST_STEP >= (1 << STEP_W)) begin : g_bad_cfg
    $error("paddle_input_ctrl: invalid parameter set");
  end

  for (genvar b = 0; b < 2*PLAYERS; b++) begin : g_btn
    input_debounce_bit #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_db (
      .clk_i        (clk),
      .rst_ni       (rst),
      .button_i     (button[b]),
      .pressed_o    (pressed[b]),
      .press_edge_o (press_edge[b])
    );
  end

  for (genvar p = 0; p < PLAYERS; p++) begin : g_player
    move_state_e       state_q, state_d;
    move_req_e         req;
    logic              vld_q, vld_d;
    logic              dir_q, dir_d;   // doubles as "last direction" for reversal detection
    logic [STEP_W-1:0] step_q, step_d;
`ifdef PADDLE_ACCEL_EN
    localparam int HOLD_W = (FAST_FRAMES > 1) ? $clog2(FAST_FRAMES) : 1;
    logic [HOLD_W-1:0] hold_cnt_q, hold_cnt_d;
`endif

    // Sampled from the registered debounced level, so a pressed update
    // landing on the tick cycle is only seen by the following tick.
    assign req = resolve_req(pressed[2*p], pressed[2*p+1]);

    always_comb begin
      state_d = state_q;
      vld_d   = 1'b0;
      dir_d   = dir_q;
      step_d  = step_q;
`ifdef PADDLE_ACCEL_EN
      hold_cnt_d = hold_cnt_q;
`endif
      if (frame_tick) begin
        if (req == REQ_NONE) begin
          state_d = IDLE;
        end else begin
          vld_d = 1'b1;
          dir_d = (req == REQ_DOWN) ? DIR_DOWN : DIR_UP;
          if (state_q == IDLE || dir_d != dir_q) begin
            state_d = SLOW;
            step_d  = STEP_W'(SLOW_STEP);
`ifdef PADDLE_ACCEL_EN
            hold_cnt_d = '0;
`endif
          end else begin
`ifdef PADDLE_ACCEL_EN
            if (state_q == SLOW) begin
              step_d = STEP_W'(SLOW_STEP);
              if (hold_cnt_q == HOLD_W'(FAST_FRAMES - 1)) state_d = FAST;
              else hold_cnt_d = hold_cnt_q + HOLD_W'(1);
            end else begin
              step_d = STEP_W'(FAST_STEP);
            end
`else
            step_d = STEP_W'(SLOW_STEP);
`endif
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        state_q <= IDLE;
        vld_q   <= 1'b0;
        dir_q   <= DIR_UP;
        step_q  <= '0;
`ifdef PADDLE_ACCEL_EN
        hold_cnt_q <= '0;
`endif
      end else begin
        state_q <= state_d;
        vld_q   <= vld_d;
        dir_q   <= dir_d;
        step_q  <= step_d;
`ifdef PADDLE_ACCEL_EN
        hold_cnt_q <= hold_cnt_d;
`endif
      end
    end

    assign move_valid[p]                 = vld_q;
    assign move_dir[p]                   = dir_q;
    assign move_step[p*STEP_W +: STEP_W] = step_q;
  end

endmodule

// File: tb/tb_paddle_input_ctrl.sv
// Self-checking bench for paddle_input_ctrl: directed steps then random buttons/ticks.
// Latency: reference model advanced once per rising edge, outputs compared on the falling edge.
// Backpressure: n/a.
module tb_paddle_input_ctrl;

  localparam int P    = 2;
  localparam int NB   = 2 * P;
  localparam int DC   = 8;
  localparam int FF   = 3;
  localparam int SW   = 4;
  localparam int SLOW_STEP = 2;
  localparam int FAST_STEP = 6;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic [NB-1:0]     button = '0;
  logic              frame_tick = 1'b0;
  logic [NB-1:0]     pressed, press_edge;
  logic [P-1:0]      move_valid, move_dir;
  logic [P*SW-1:0]   move_step;

  always #10 clk = ~clk;

  paddle_input_ctrl #(
    .PLAYERS(P), .DEBOUNCE_CYCLES(DC), .FAST_FRAMES(FF),
    .STEP_W(SW), .SLOW_STEP(SLOW_STEP), .FAST_STEP(FAST_STEP)
  ) dut (
    .clk(clk), .rst(rst), .button(button), .frame_tick(frame_tick),
    .pressed(pressed), .press_edge(press_edge),
    .move_valid(move_valid), .move_dir(move_dir), .move_step(move_step)
  );

  int total  = 0;
  int passed = 0;

  // Reference model: button sample history, debounced levels, hold length per player.
  bit [NB-1:0] h1, h2, pm, pm_last, e_m;
  int          stable_run [NB];
  int          hold_len   [P];
  bit          last_dir   [P];
  bit [P-1:0]  v_m, d_m;
  bit [P*SW-1:0] s_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
  endtask

  task automatic model_reset();
    h1 = '0; h2 = '0; pm = '0; pm_last = '0; e_m = '0;
    v_m = '0; d_m = '0; s_m = '0;
    for (int b = 0; b < NB; b++) stable_run[b] = 0;
    for (int p = 0; p < P; p++) begin hold_len[p] = 0; last_dir[p] = 1'b0; end
  endtask

  // Continuous hold: ticks 1..FF+1 slow, later ticks fast.
  function automatic int step_for(input int n);
`ifdef PADDLE_ACCEL_EN
    return (n > FF + 1) ? FAST_STEP : SLOW_STEP;
`else
    return SLOW_STEP;
`endif
  endfunction

  task automatic model_edge();
    bit up, dn;
    if (!rst) begin
      model_reset();
      return;
    end
    v_m = '0;
    if (frame_tick) begin
      for (int p = 0; p < P; p++) begin
        up = pm[2*p];
        dn = pm[2*p+1];
        if (up != dn) begin
          if (hold_len[p] > 0 && dn == last_dir[p]) hold_len[p]++;
          else hold_len[p] = 1;
          last_dir[p] = dn;
          v_m[p] = 1'b1;
          d_m[p] = dn;
          s_m[p*SW +: SW] = SW'(step_for(hold_len[p]));
        end else begin
          hold_len[p] = 0;
        end
      end
    end
    e_m = pm & ~pm_last;
    pm_last = pm;
    // A change is accepted after DC consecutive synchronised samples disagreeing.
    for (int b = 0; b < NB; b++) begin
      if (h2[b] != pm[b]) stable_run[b]++;
      else stable_run[b] = 0;
      if (stable_run[b] == DC) begin
        pm[b] = ~pm[b];
        stable_run[b] = 0;
      end
    end
    h2 = h1;
    h1 = button;
  endtask

  task automatic cyc();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("pressed",    32'(pressed),    32'(pm));
    chk("press_edge", 32'(press_edge), 32'(e_m));
    chk("move_valid", 32'(move_valid), 32'(v_m));
    chk("move_dir",   32'(move_dir),   32'(d_m));
    chk("move_step",  32'(move_step),  32'(s_m));
  endtask

  task automatic tick_once();
    frame_tick = 1'b1;
    cyc();
    frame_tick = 1'b0;
  endtask

  int exp_seq [6];

  initial begin
`ifdef PADDLE_ACCEL_EN
    exp_seq = '{2, 2, 2, 2, 6, 6};
`else
    exp_seq = '{2, 2, 2, 2, 2, 2};
`endif
    model_reset();
    #5;
    chk("rst_pressed",    32'(pressed),    0);
    chk("rst_press_edge", 32'(press_edge), 0);
    chk("rst_move_valid", 32'(move_valid), 0);
    chk("rst_move_dir",   32'(move_dir),   0);
    chk("rst_move_step",  32'(move_step),  0);
    repeat (2) cyc();
    rst = 1'b1;
    repeat (2) cyc();

    // Debounce latency: pressed after exactly 10 edges, edge pulse at 11.
    button[0] = 1'b1;
    repeat (9) cyc();
    chk("db_edge9", 32'(pressed[0]), 0);
    cyc();
    chk("db_edge10", 32'(pressed[0]), 1);
    chk("no_edge_yet", 32'(press_edge[0]), 0);
    cyc();
    chk("edge_at11", 32'(press_edge[0]), 1);
    cyc();
    chk("edge_one_cycle", 32'(press_edge[0]), 0);

    // Release, then a 5-cycle glitch must not be accepted.
    button[0] = 1'b0;
    repeat (12) cyc();
    chk("released", 32'(pressed[0]), 0);
    button[0] = 1'b1;
    repeat (5) cyc();
    button[0] = 1'b0;
    repeat (15) cyc();
    chk("glitch_rejected", 32'(pressed[0]), 0);

    // Continuous hold of P0 up: 6 ticks.
    button[0] = 1'b1;
    repeat (12) cyc();
    for (int i = 0; i < 6; i++) begin
      tick_once();
      chk("hold_valid", 32'(move_valid[0]), 1);
      chk("hold_dir",   32'(move_dir[0]),   0);
      chk("hold_step",  32'(move_step[0 +: SW]), 32'(exp_seq[i]));
      cyc();
      chk("valid_one_cycle", 32'(move_valid[0]), 0);
    end

    // P1 both pressed -> no command; release up -> down at slow step.
    button[3:2] = 2'b11;
    repeat (12) cyc();
    tick_once();
    chk("conflict_none", 32'(move_valid[1]), 0);
    button[2] = 1'b0;
    repeat (12) cyc();
    tick_once();
    chk("p1_valid", 32'(move_valid[1]), 1);
    chk("p1_dir",   32'(move_dir[1]),   1);
    chk("p1_step",  32'(move_step[SW +: SW]), 2);

    // Reversal of P0 without passing through NONE restarts slow.
    button[1:0] = 2'b10;
    repeat (12) cyc();
    tick_once();
    chk("rev_valid", 32'(move_valid[0]), 1);
    chk("rev_dir",   32'(move_dir[0]),   1);
    chk("rev_step",  32'(move_step[0 +: SW]), 2);

    // Asynchronous reset mid-hold clears outputs immediately.
    #1 rst = 1'b0;
    #1;
    chk("arst_pressed",    32'(pressed),    0);
    chk("arst_move_valid", 32'(move_valid), 0);
    chk("arst_move_dir",   32'(move_dir),   0);
    chk("arst_move_step",  32'(move_step),  0);
    model_reset();
    repeat (2) cyc();
    rst = 1'b1;

    // Fresh debounce after reset, then 20 back-to-back ticks holding down.
    repeat (12) cyc();
    frame_tick = 1'b1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      chk("bb_valid", 32'(move_valid[0]), 1);
      chk("bb_dir",   32'(move_dir[0]),   1);
      chk("bb_step",  32'(move_step[0 +: SW]), 32'(step_for(i + 1)));
    end
    frame_tick = 1'b0;

    // Random buttons and ticks against the model.
    for (int n = 0; n < 1500; n++) begin
      for (int b = 0; b < NB; b++)
        if ($urandom_range(0, 19) == 0) button[b] = ~button[b];
      frame_tick = ($urandom_range(0, 3) == 0);
      cyc();
    end
    frame_tick = 1'b0;

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/paddle_input_ctrl.md
# paddle_input_ctrl

Parametrised player-input front end for the Pong engine. It replaces the fixed 4-button debouncer path with one block that serves `PLAYERS` players. The block synchronises and debounces every button, resolves up/down conflicts, and issues one paddle-move command per player per video frame, with acceleration after a sustained hold. It sits between the board buttons and `pong_logic`, clocked on the 50 MHz `clk`, and consumes a one-cycle frame tick from the display path.

## Interface
- `PLAYERS`, 2: number of players; each player has one up and one down button.
- `DEBOUNCE_CYCLES`, 500000: number of stable synchronised cycles needed to accept a change (10 ms at 50 MHz); minimum 2.
- `FAST_FRAMES`, 16: number of consecutive held frames at slow speed before switching to fast; minimum 1.
- `STEP_W`, 4: width of each step field.
- `SLOW_STEP`, 2: pixels per frame while slow.
- `FAST_STEP`, 6: pixels per frame while fast; must fit in `STEP_W`.

Ports:
- `clk`  in  1: system clock, 50 MHz.
- `rst`  in  1: reset, asynchronous, active-low.
- `button`  in  2*PLAYERS: raw buttons, active-high, asynchronous. Bit 2p is player p up; bit 2p+1 is player p down.
- `frame_tick`  in  1: single-cycle pulse per frame, synchronous to `clk`.
- `pressed`  out  2*PLAYERS: debounced button levels.
- `press_edge`  out  2*PLAYERS: one-cycle pulse on each debounced 0→1 transition.
- `move_valid`  out  PLAYERS: one-cycle move command.
- `move_dir`  out  PLAYERS: direction, 1 = down, 0 = up; valid while `move_valid` is high.
- `move_step`  out  PLAYERS*STEP_W: step size; field p is bits [p*STEP_W +: STEP_W].

## Operation
- **Per button:**
  - 2-flop synchroniser feeding a debounce counter of width $clog2(DEBOUNCE_CYCLES).
  - While the synchronised value equals `pressed`, the counter is held at 0.
  - While it differs, the counter increments. When it reaches DEBOUNCE_CYCLES-1, `pressed` toggles and the counter clears.
  - A single mismatching-then-matching glitch clears the counter; there is no partial credit.
- **`press_edge`:** registered; high for exactly the cycle after `pressed` rises.
- **Per-player request:**
  - UP when only up is pressed; DOWN when only down is pressed.
  - NONE when neither is pressed, or both are pressed.
- **Per-player FSM (IDLE, SLOW, FAST) plus `hold_cnt`:** evaluated only on cycles where `frame_tick` is high; otherwise the state is frozen.
  - Request NONE: go to IDLE; no move.
  - Request present and (state is IDLE or request differs from the last direction): go to SLOW, `hold_cnt` = 0, emit SLOW_STEP in the new direction.
  - SLOW, same direction: emit SLOW_STEP. If `hold_cnt` == FAST_FRAMES-1, go to FAST; otherwise increment `hold_cnt`.
  - FAST, same direction: emit FAST_STEP.
- **Resulting step sequence** for a continuous hold: ticks 1..FAST_FRAMES+1 emit SLOW_STEP; tick FAST_FRAMES+2 onward emit FAST_STEP.
- **Direction reversal** without passing through NONE restarts at SLOW.
- **Players are fully independent;** simultaneous commands on all players are allowed.

## Timing
- **Reset values** while `rst` is low: all outputs 0, all counters 0, all FSMs IDLE, `pressed` = 0, synchronisers 0.
- **Debounce latency:** a clean level change on `button` appears on `pressed` exactly 2 + DEBOUNCE_CYCLES rising edges later.
- **Edge latency:** `press_edge` appears 1 cycle after `pressed` rises.
- **Move latency:** `move_valid`, `move_dir` and `move_step` are registered and appear on the cycle after `frame_tick`.
  - `move_valid` is high for exactly 1 cycle.
  - `move_dir` and `move_step` hold their values until the next command.
- **Same-cycle update:** the request is sampled from `pressed` in the same cycle as `frame_tick`. A `pressed` update in that same cycle is not seen until the next tick.
- **Back-to-back ticks** are allowed (one command per tick).
- **Reset mid-hold:** returns to IDLE. The first tick after release with the button still debounced-pressed requires a fresh debounce first, because `pressed` restarts at 0.

## Configuration
- `PADDLE_ACCEL_EN` defined:
  - FSM as above.
- `PADDLE_ACCEL_EN` undefined:
  - FAST state and `hold_cnt` are not built.
  - Every move uses SLOW_STEP.
  - FAST_FRAMES and FAST_STEP are ignored.

## Structure
- **Package `pong_input_pkg`:**
  - FSM state typedef (IDLE/SLOW/FAST).
  - Direction constants DIR_UP = 0 and DIR_DOWN = 1.
  - Default step and debounce constants.
- **Sub-module `input_debounce_bit`:** synchroniser, counter and stable register for one button. Instantiated 2*PLAYERS times via generate.
- **Player FSMs:** generated inline in the top module.

## Test plan
- DEBOUNCE_CYCLES=8; assert `button[0]` and hold → `pressed[0]` rises exactly 10 cycles later; `press_edge[0]` is high for 1 cycle at cycle 11.
- `button[0]` pulses high for 5 cycles, then low → `pressed[0]` stays 0, no edge.
- FAST_FRAMES=3; hold P0 up; tick 6 times → `move_valid[0]` ×6, `move_dir` = 0; steps are 2, 2, 2, 2, 6, 6.
- Hold P1 up and down together; tick → no `move_valid[1]`. Release up; tick → `move_valid[1]`, dir = 1, step 2.
- P0 in FAST moving up; switch to down between ticks → next command is dir = 1, step 2. Assert reset mid-hold → all outputs 0 the same cycle.
- Without `PADDLE_ACCEL_EN`: 20 ticks holding down → every step is 2.
